// File: rtl/grf_writeback_pkg.sv
// ----------------------------------------------------------------------------
// mips_defs
// Shared encodings for the MIPS write-back stage.
//   WBSEL_* : result source select carried with each instruction
//   LD_*    : load width / signedness carried with each load
// ----------------------------------------------------------------------------
package mips_defs;

    // Result source for the GRF write data.
    localparam logic [1:0] WBSEL_ALU  = 2'd0;
    localparam logic [1:0] WBSEL_LOAD = 2'd1;
    localparam logic [1:0] WBSEL_LINK = 2'd2;
    // 2'd3 is reserved and falls back to the ALU result.

    // Load types; any other code behaves as a full-word load.
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    // JAL/JALR link address is the instruction after the delay slot.
    localparam int LINK_OFFSET = 8;

endpackage

// File: rtl/grf_writeback_load_ext.sv
// ----------------------------------------------------------------------------
// load_ext
// Combinational sub-word load alignment and extension (little-endian,
// byte 0 = rdata[7:0]).
//   rdata   in  W   raw data-memory word
//   addr_lo in  2   low address bits of the load
//   ldtype  in  3   LW/LH/LHU/LB/LBU (unknown codes act as LW)
//   data    out W   aligned, sign/zero-extended result
// ----------------------------------------------------------------------------
module load_ext
    import mips_defs::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rdata,
    input  logic [1:0]   addr_lo,
    input  logic [2:0]   ldtype,
    output logic [W-1:0] data
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Halfword loads select on addr_lo[1] only; an unaligned addr_lo[0]
    // is ignored rather than trapped here.
    assign sel_byte = byte_lane[addr_lo];
    assign sel_half = half_lane[addr_lo[1]];

    always_comb begin
        data = rdata;
        case (ldtype)
            LD_LH:   data = {{(W-16){sel_half[15]}}, sel_half};
            LD_LHU:  data = {{(W-16){1'b0}},         sel_half};
            LD_LB:   data = {{(W-8){sel_byte[7]}},   sel_byte};
            LD_LBU:  data = {{(W-8){1'b0}},          sel_byte};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/grf_writeback.sv
// ----------------------------------------------------------------------------
// grf_writeback
// MIPS WB stage: MEM/WB pipeline register, result selection and the GRF
// write port, plus the WB forwarding source and a retired-instruction count.
//   clk, reset                 clock (rising edge), async active-low reset
//   stall / flush              hold WB contents / insert a bubble (flush wins)
//   mem_valid .. mem_ldtype    instruction fields from the MEM stage
//   A3, WD3, WE3, PC           GRF write address/data/enable and trace PC
//   fwd_valid, fwd_rd, fwd_data  forwarding source for the hazard unit
//   instret                    count of retired instructions (wraps)
// ----------------------------------------------------------------------------
module grf_writeback
    import mips_defs::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [PC_W-1:0]   mem_pc,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_rd,
    input  logic [1:0]        mem_wbsel,
    input  logic [PC_W-1:0]   mem_alu,
    input  logic [PC_W-1:0]   mem_rdata,
    input  logic [2:0]        mem_ldtype,
    output logic [4:0]        A3,
    output logic [PC_W-1:0]   WD3,
    output logic              WE3,
    output logic [PC_W-1:0]   PC,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [PC_W-1:0]   fwd_data,
    output logic [CNT_W-1:0]  instret
);

    // ------------------------------------------------------------------
    // WB register state
    // ------------------------------------------------------------------
    logic              wb_valid_reg,    wb_valid_next;
    logic [PC_W-1:0]   wb_pc_reg,       wb_pc_next;
    logic              wb_regwrite_reg, wb_regwrite_next;
    logic [4:0]        wb_rd_reg,       wb_rd_next;
    logic [1:0]        wb_wbsel_reg,    wb_wbsel_next;
    logic [PC_W-1:0]   wb_alu_reg,      wb_alu_next;
    logic [PC_W-1:0]   wb_rdata_reg,    wb_rdata_next;
    logic [2:0]        wb_ldtype_reg,   wb_ldtype_next;
    // Set once the held instruction has had its one write/retire cycle, so a
    // stall does not repeat the GRF write or the count.
    logic              written_reg,     written_next;
    logic [CNT_W-1:0]  instret_reg,     instret_next;

    logic              retire;
    logic [PC_W-1:0]   load_data;
    logic [PC_W-1:0]   result;

    always_comb begin
        wb_valid_next    = wb_valid_reg;
        wb_pc_next       = wb_pc_reg;
        wb_regwrite_next = wb_regwrite_reg;
        wb_rd_next       = wb_rd_reg;
        wb_wbsel_next    = wb_wbsel_reg;
        wb_alu_next      = wb_alu_reg;
        wb_rdata_next    = wb_rdata_reg;
        wb_ldtype_next   = wb_ldtype_reg;
        written_next     = written_reg;

        if (flush) begin
            wb_valid_next = 1'b0;
            written_next  = 1'b0;
        end else if (stall) begin
            // A bubble being held never counts as written.
            written_next  = wb_valid_reg;
        end else begin
            wb_valid_next    = mem_valid;
            wb_pc_next       = mem_pc;
            wb_regwrite_next = mem_regwrite;
            wb_rd_next       = mem_rd;
            wb_wbsel_next    = mem_wbsel;
            wb_alu_next      = mem_alu;
            wb_rdata_next    = mem_rdata;
            wb_ldtype_next   = mem_ldtype;
            written_next     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_reg    <= 1'b0;
            wb_pc_reg       <= '0;
            wb_regwrite_reg <= 1'b0;
            wb_rd_reg       <= '0;
            wb_wbsel_reg    <= '0;
            wb_alu_reg      <= '0;
            wb_rdata_reg    <= '0;
            wb_ldtype_reg   <= '0;
            written_reg     <= 1'b0;
        end else begin
            wb_valid_reg    <= wb_valid_next;
            wb_pc_reg       <= wb_pc_next;
            wb_regwrite_reg <= wb_regwrite_next;
            wb_rd_reg       <= wb_rd_next;
            wb_wbsel_reg    <= wb_wbsel_next;
            wb_alu_reg      <= wb_alu_next;
            wb_rdata_reg    <= wb_rdata_next;
            wb_ldtype_reg   <= wb_ldtype_next;
            written_reg     <= written_next;
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter. The count is taken during the single
    // fresh cycle of each instruction, so a later flush cannot undo it.
    // ------------------------------------------------------------------
    assign retire = wb_valid_reg & ~written_reg;

    always_comb begin
        instret_next = instret_reg;
        if (retire) begin
            instret_next = instret_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_reg <= '0;
        end else begin
            instret_reg <= instret_next;
        end
    end

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    load_ext #(
        .W (PC_W)
    ) u_load_ext (
        .rdata   (wb_rdata_reg),
        .addr_lo (wb_alu_reg[1:0]),
        .ldtype  (wb_ldtype_reg),
        .data    (load_data)
    );

    always_comb begin
        result = wb_alu_reg;
        case (wb_wbsel_reg)
            WBSEL_LOAD: result = load_data;
            WBSEL_LINK: result = wb_pc_reg + PC_W'(LINK_OFFSET);
            default:    result = wb_alu_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign A3        = wb_rd_reg;
    assign WD3       = result;
    assign PC        = wb_pc_reg;
    // rd==0 still pulses the write port; the GRF drops it.
    assign WE3       = wb_valid_reg & wb_regwrite_reg & ~written_reg;
    // Forwarding stays valid for the whole time the producer sits in WB.
    assign fwd_valid = wb_valid_reg & wb_regwrite_reg & (wb_rd_reg != 5'd0);
    assign fwd_rd    = wb_rd_reg;
    assign fwd_data  = result;
    assign instret   = instret_reg;

endmodule

// File: tb/tb_grf_writeback.sv
module tb_grf_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        mem_valid, mem_regwrite;
    logic [31:0] mem_pc, mem_alu, mem_rdata;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_ldtype;

    logic [4:0]  A3, fwd_rd, s_A3, s_fwd_rd;
    logic [31:0] WD3, PC, fwd_data, instret, s_WD3, s_PC, s_fwd_data;
    logic        WE3, fwd_valid, s_WE3, s_fwd_valid;
    logic [3:0]  s_instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grf_writeback u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_alu(mem_alu),
        .mem_rdata(mem_rdata), .mem_ldtype(mem_ldtype),
        .A3(A3), .WD3(WD3), .WE3(WE3), .PC(PC),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .instret(instret)
    );

    // Narrow-counter copy so the counter wrap is reachable in a short run.
    grf_writeback #(.PC_W(32), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_regwrite(mem_regwrite),
        .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_alu(mem_alu),
        .mem_rdata(mem_rdata), .mem_ldtype(mem_ldtype),
        .A3(s_A3), .WD3(s_WD3), .WE3(s_WE3), .PC(s_PC),
        .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
        .instret(s_instret)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [2:0]  ldtype;
        logic        exp_we;
        logic        exp_fwd;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        string       name;
        logic        we;
        logic        fwd;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t   sb[$];
    vec_t   vecs[15];
    int     exp_instret = 0;
    logic   model_retire = 1'b0;   // WB holds a not-yet-counted instruction

    function automatic vec_t mk(string n, logic v, logic rw, logic [4:0] rd,
                                logic [1:0] ws, logic [31:0] pc, logic [31:0] alu,
                                logic [31:0] rdat, logic [2:0] lt,
                                logic ew, logic ef, logic [31:0] wd);
        vec_t r;
        r.name = n; r.valid = v; r.regwrite = rw; r.rd = rd; r.wbsel = ws;
        r.pc = pc; r.alu = alu; r.rdata = rdat; r.ldtype = lt;
        r.exp_we = ew; r.exp_fwd = ef; r.exp_wd = wd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        mem_valid = v.valid; mem_regwrite = v.regwrite; mem_rd = v.rd;
        mem_wbsel = v.wbsel; mem_pc = v.pc; mem_alu = v.alu;
        mem_rdata = v.rdata; mem_ldtype = v.ldtype;
    endtask

    // One MEM->WB transfer: expectation queued at drive time, compared after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        drive(v);
        stall = 1'b0; flush = 1'b0;
        if (model_retire) exp_instret++;
        model_retire = v.valid;
        e.name = v.name; e.we = v.exp_we; e.fwd = v.exp_fwd; e.a3 = v.rd;
        e.wd = v.exp_wd; e.pc = v.pc; e.cnt = exp_instret;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.name, ".WE3"},       {31'b0, WE3},       {31'b0, e.we});
        chk({e.name, ".fwd_valid"}, {31'b0, fwd_valid}, {31'b0, e.fwd});
        chk({e.name, ".A3"},        {27'b0, A3},        {27'b0, e.a3});
        chk({e.name, ".WD3"},       WD3,                e.wd);
        chk({e.name, ".fwd_data"},  fwd_data,           e.wd);
        chk({e.name, ".PC"},        PC,                 e.pc);
        chk({e.name, ".instret"},   instret,            e.cnt);
        $display("txn %-10s A3=%0d WD3=%h WE3=%b fwd=%b instret=%0d",
                 e.name, A3, WD3, WE3, fwd_valid, instret);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".A3"},        {27'b0, A3},        32'd0);
        chk({tag, ".WD3"},       WD3,                32'd0);
        chk({tag, ".WE3"},       {31'b0, WE3},       32'd0);
        chk({tag, ".PC"},        PC,                 32'd0);
        chk({tag, ".fwd_valid"}, {31'b0, fwd_valid}, 32'd0);
        chk({tag, ".fwd_rd"},    {27'b0, fwd_rd},    32'd0);
        chk({tag, ".fwd_data"},  fwd_data,           32'd0);
        chk({tag, ".instret"},   instret,            32'd0);
    endtask

    initial begin
        vec_t v;
        //            name        vld rw rd  sel  pc            alu           rdata         lt    we fwd wd
        vecs[0]  = mk("alu",       1, 1, 8,  0, 32'h0000_1000, 32'h0000_1234, 32'h0,        3'd0, 1, 1, 32'h0000_1234);
        vecs[1]  = mk("lb_lo3",    1, 1, 9,  1, 32'h0000_1004, 32'h0000_2003, 32'h80FF_1234, 3'd3, 1, 1, 32'hFFFF_FF80);
        vecs[2]  = mk("lbu_lo3",   1, 1, 10, 1, 32'h0000_1008, 32'h0000_2003, 32'h80FF_1234, 3'd4, 1, 1, 32'h0000_0080);
        vecs[3]  = mk("lh_lo2",    1, 1, 11, 1, 32'h0000_100C, 32'h0000_2002, 32'h80FF_1234, 3'd1, 1, 1, 32'hFFFF_80FF);
        vecs[4]  = mk("lhu_lo3",   1, 1, 12, 1, 32'h0000_1010, 32'h0000_2003, 32'h80FF_1234, 3'd2, 1, 1, 32'h0000_80FF);
        vecs[5]  = mk("lh_lo0",    1, 1, 13, 1, 32'h0000_1014, 32'h0000_2000, 32'h80FF_9234, 3'd1, 1, 1, 32'hFFFF_9234);
        vecs[6]  = mk("lb_lo1",    1, 1, 14, 1, 32'h0000_1018, 32'h0000_2001, 32'h80FF_1234, 3'd3, 1, 1, 32'h0000_0012);
        vecs[7]  = mk("lw",        1, 1, 15, 1, 32'h0000_101C, 32'h0000_2003, 32'h80FF_1234, 3'd0, 1, 1, 32'h80FF_1234);
        vecs[8]  = mk("lt7_as_lw", 1, 1, 16, 1, 32'h0000_1020, 32'h0000_2001, 32'hCAFE_F00D, 3'd7, 1, 1, 32'hCAFE_F00D);
        vecs[9]  = mk("jal",       1, 1, 31, 2, 32'h0000_3000, 32'h0000_0000, 32'h0,        3'd0, 1, 1, 32'h0000_3008);
        vecs[10] = mk("wbsel3",    1, 1, 17, 3, 32'h0000_1024, 32'hDEAD_BEEF, 32'h1111_1111, 3'd0, 1, 1, 32'hDEAD_BEEF);
        vecs[11] = mk("rd0",       1, 1, 0,  0, 32'h0000_1028, 32'h0000_0055, 32'h0,        3'd0, 1, 0, 32'h0000_0055);
        vecs[12] = mk("bubble",    0, 1, 18, 0, 32'h0000_102C, 32'h0000_0066, 32'h0,        3'd0, 0, 0, 32'h0000_0066);
        vecs[13] = mk("nowrite",   1, 0, 19, 0, 32'h0000_1030, 32'h0000_0077, 32'h0,        3'd0, 0, 0, 32'h0000_0077);
        vecs[14] = mk("link_wrap", 1, 1, 31, 2, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0,        3'd0, 1, 1, 32'h0000_0004);

        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        v = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 15; i++) begin
            step(vecs[i]);
        end

        // Stall held 3 cycles on a writer: one WE3 pulse, forwarding throughout, one count
        step(mk("stall_ld", 1, 1, 9, 0, 32'h0000_4000, 32'h0000_00AA, 32'h0, 3'd0, 1, 1, 32'h0000_00AA));
        stall = 1'b1;
        v = mk("next", 1, 1, 20, 0, 32'h0000_5000, 32'h0000_0BAD, 32'h0, 3'd0, 0, 0, 0);
        drive(v);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                exp_instret++;
                model_retire = 1'b0;
            end
            chk("stall.WE3",       {31'b0, WE3},       32'd0);
            chk("stall.fwd_valid", {31'b0, fwd_valid}, 32'd1);
            chk("stall.A3",        {27'b0, A3},        32'd9);
            chk("stall.WD3",       WD3,                32'h0000_00AA);
            chk("stall.instret",   instret,            exp_instret);
            $display("txn stall%0d     A3=%0d WD3=%h WE3=%b fwd=%b instret=%0d",
                     i, A3, WD3, WE3, fwd_valid, instret);
        end

        // Flush together with stall: bubble wins, count not retracted
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_stall.WE3",       {31'b0, WE3},       32'd0);
        chk("flush_stall.fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("flush_stall.instret",   instret,            exp_instret);
        $display("txn flush_stl  WE3=%b fwd=%b instret=%0d", WE3, fwd_valid, instret);
        flush = 1'b0; stall = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("after_flush.WE3",     {31'b0, WE3}, 32'd0);
        chk("after_flush.instret", instret,      exp_instret);
        $display("txn after_fl   WE3=%b instret=%0d", WE3, instret);

        // Reset asserted mid-stall clears everything without waiting for a clock
        step(mk("rst_ld", 1, 1, 12, 0, 32'h0000_6000, 32'h0000_0077, 32'h0, 3'd0, 1, 1, 32'h0000_0077));
        stall = 1'b1;
        @(posedge clk); #1;
        exp_instret++;
        chk("rst_stall.instret", instret, exp_instret);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_stall_reset");
        $display("txn mid_reset  WE3=%b instret=%0d", WE3, instret);
        exp_instret = 0;
        model_retire = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_stall.WE3",       {31'b0, WE3},       32'd0);
        chk("post_reset_stall.fwd_valid", {31'b0, fwd_valid}, 32'd0);
        step(mk("post_rst", 1, 1, 12, 0, 32'h0000_6000, 32'h0000_0077, 32'h0, 3'd0, 1, 1, 32'h0000_0077));

        // Counter wrap on the narrow copy: 16 retirements bring 4 bits back to 0
        reset = 1'b0;
        #1;
        reset = 1'b1;
        stall = 1'b0; flush = 1'b0;
        v = mk("wrap", 1, 0, 3, 0, 32'h0000_7000, 32'h0, 32'h0, 3'd0, 0, 0, 0);
        drive(v);
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk); #1;
            chk("wrap.instret32", instret, 32'(n - 1));
            chk("wrap.instret4",  {28'b0, s_instret}, 32'((n - 1) % 16));
            $display("txn wrap%0d     instret=%0d small=%0d", n, instret, s_instret);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
